wb_regfile: RTL and testbench

Architectural integer register file for the RV32I core: the consumer end of the MEM/WB write-back path. It accepts the registered write-back triple (data, destination, enable) on a synchronous write port. It serves the decode stage through two combinational read ports plus one debug read port. x0 is hard-wired to zero, and an optional write-to-read bypass resolves same-cycle write-back/decode overlap.

---
 rtl/wb_regfile_pkg.sv | 16 +
 rtl/wb_regfile_read_port.sv | 46 ++++
 rtl/wb_regfile.sv | 86 ++++++++
 tb/tb_wb_regfile.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared core constants for the RV32I pipeline: data width, register count,
// register index width and the hard-wired zero register index.
package wb_regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // True when the index names x0, which has no storage and reads 0.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_regfile_read_port.sv
// regfile_read_port: one combinational decode-stage read port.
// It selects an entry from the flat register vector and forces x0 to zero.
// When WB_REGFILE_BYPASS_EN is defined, it also forwards the write-back data
// presented in the same cycle to the read port.
module regfile_read_port
    import wb_regfile_pkg::*;
#(
    parameter int W = XLEN,
    parameter int N = NUM_REGS
) (
    input  logic                        reset_i,
    input  logic [N-1:1][W-1:0]         regs_i,
    input  logic [W-1:0]                wb_data_i,
    input  logic [REG_ADDR_W-1:0]       wb_addr_i,
    input  logic                        wb_en_i,
    input  logic [REG_ADDR_W-1:0]       addr_i,
    output logic [W-1:0]                rd_data_o
);

    logic [W-1:0] arr_data;
    logic         byp_hit;

    // Array lookup. An index of 0 matches no entry, so the zero default holds.
    always_comb begin
        arr_data = '0;
        for (int i = 1; i < N; i++) begin
            if (addr_i == i[REG_ADDR_W-1:0]) begin
                arr_data = regs_i[i];
            end
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    // Forward a write that targets this index in the current cycle.
    // Reset suppresses forwarding, and x0 never forwards.
    assign byp_hit = !reset_i && wb_en_i && (wb_addr_i == addr_i) && !is_zero_reg(addr_i);
`else
    // Array-only build: the write-back inputs have no effect on this port.
    assign byp_hit = 1'b0;
    logic unused_wb;
    assign unused_wb = &{1'b0, reset_i, wb_en_i, wb_addr_i, wb_data_i};
`endif

    assign rd_data_o = byp_hit ? wb_data_i : arr_data;

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: RV32I architectural integer register file.
// It has one synchronous write-back port, two decode read ports (rs1 and rs2)
// and one debug read port. x0 is hard-wired to zero.
// Optional feature macro: WB_REGFILE_BYPASS_EN adds same-cycle write-to-read
// forwarding on rs1 and rs2. dbg_data is never forwarded.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN     = wb_regfile_pkg::XLEN,
    parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [XLEN-1:0]         wb_data,
    input  logic [REG_ADDR_W-1:0]   wb_rd_addr,
    input  logic                    wb_reg_enable,
    input  logic [REG_ADDR_W-1:0]   rs1_addr,
    output logic [XLEN-1:0]         rs1_data,
    input  logic [REG_ADDR_W-1:0]   rs2_addr,
    output logic [XLEN-1:0]         rs2_data,
    input  logic [REG_ADDR_W-1:0]   dbg_addr,
    output logic [XLEN-1:0]         dbg_data
);

    localparam int NUM_RD = 2;

    // Storage for x1..x31 only. x0 has no storage.
    logic [NUM_REGS-1:1][XLEN-1:0] regs_q, regs_d;

    logic [NUM_RD-1:0][REG_ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0]       rd_data;

    // Next-state of the array: at most one entry is replaced by the write-back.
    always_comb begin
        regs_d = regs_q;
        if (wb_reg_enable && !is_zero_reg(wb_rd_addr)) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wb_rd_addr == i[REG_ADDR_W-1:0]) begin
                    regs_d[i] = wb_data;
                end
            end
        end
    end

    // Array update. Reset has priority and drops any write presented with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // Two identical decode read ports, each with its own bypass compare.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_read_port #(
            .W (XLEN),
            .N (NUM_REGS)
        ) u_rd (
            .reset_i   (reset),
            .regs_i    (regs_q),
            .wb_data_i (wb_data),
            .wb_addr_i (wb_rd_addr),
            .wb_en_i   (wb_reg_enable),
            .addr_i    (rd_addr[p]),
            .rd_data_o (rd_data[p])
        );
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];

    // Debug port returns only the stored array contents and is never forwarded.
    always_comb begin
        dbg_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (dbg_addr == i[REG_ADDR_W-1:0]) begin
                dbg_data = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile. A behavioural register model is updated
// at each rising edge from the inputs that the bench drove. Read expectations
// come from the read rules: x0 reads 0, forwarding applies only in the bypass
// build, and otherwise the stored value is returned.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_enable;
    logic [4:0]  rs1_addr, rs2_addr, dbg_addr;
    logic [31:0] rs1_data, rs2_data, dbg_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .wb_data       (wb_data),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_enable (wb_reg_enable),
        .rs1_addr      (rs1_addr),
        .rs1_data      (rs1_data),
        .rs2_addr      (rs2_addr),
        .rs2_data      (rs2_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, no result");
        $fatal(1, "watchdog");
    end

    // Expected decode-port value for the inputs currently presented.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && !reset && wb_reg_enable && wb_rd_addr == a) return wb_data;
        return model[a];
    endfunction

    // Advance one clock edge, apply the architectural effect, and return at the negedge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wb_reg_enable && wb_rd_addr != 5'd0) begin
            model[wb_rd_addr] = wb_data;
        end
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wb_reg_enable = 1'b1; wb_rd_addr = a; wb_data = d;
        tick();
        wb_reg_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_reg_enable = 1'b0; wb_rd_addr = 0; wb_data = 0;
        rs1_addr = 0; rs2_addr = 0; dbg_addr = 0;
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = a[4:0]; rs2_addr = 5'(31 - a); dbg_addr = a[4:0];
            #1;
            checks++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_read a=%0d: rs1=%h rs2=%h dbg=%h, required all 0",
                         a, rs1_data, rs2_data, dbg_data);
            end
            tick();
        end
    endtask

    task automatic test_basic_write();
        write_reg(5'd5, 32'hDEADBEEF);
        rs1_addr = 5; rs2_addr = 5; dbg_addr = 5;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF || rs2_data !== 32'hDEADBEEF || dbg_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_write: rs1=%h rs2=%h dbg=%h, required deadbeef", rs1_data, rs2_data, dbg_data);
        end
    endtask

    task automatic test_x0();
        wb_reg_enable = 1'b1; wb_rd_addr = 0; wb_data = 32'h12345678;
        rs1_addr = 0; rs2_addr = 0; dbg_addr = 0;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_during_write: rs1=%h rs2=%h, required 0", rs1_data, rs2_data);
        end
        tick();
        wb_reg_enable = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_after_write: rs1=%h dbg=%h, required 0", rs1_data, dbg_data);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        write_reg(5'd7, 32'h1);
        wb_reg_enable = 1'b1; wb_rd_addr = 7; wb_data = 32'hCAFEF00D;
        rs1_addr = 7; dbg_addr = 7;
        #1;
        want = BYP ? 32'hCAFEF00D : 32'h1;
        checks++;
        if (rs1_data !== want) begin
            errors++;
            $display("FAIL bypass_same_cycle: rs1=%h, required %h", rs1_data, want);
        end
        checks++;
        if (dbg_data !== 32'h1) begin
            errors++;
            $display("FAIL bypass_dbg_unforwarded: dbg=%h, required 00000001", dbg_data);
        end
        tick();
        wb_reg_enable = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'hCAFEF00D || dbg_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL bypass_after_edge: rs1=%h dbg=%h, required cafef00d", rs1_data, dbg_data);
        end
    endtask

    task automatic test_reset_priority();
        write_reg(5'd3, 32'h5A5A1234);
        reset = 1'b1; wb_reg_enable = 1'b1; wb_rd_addr = 3; wb_data = 32'hAAAA5555;
        rs1_addr = 3; dbg_addr = 3;
        #1;
        checks++;
        if (rs1_data !== 32'h5A5A1234) begin
            errors++;
            $display("FAIL reset_no_bypass: rs1=%h, required 5a5a1234", rs1_data);
        end
        tick();
        reset = 1'b0; wb_reg_enable = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_drops_write: rs1=%h dbg=%h, required 0", rs1_data, dbg_data);
        end
    endtask

    task automatic test_dual_read();
        logic [31:0] want;
        write_reg(5'd1, 32'h11);
        write_reg(5'd2, 32'h22);
        wb_reg_enable = 1'b1; wb_rd_addr = 2; wb_data = 32'h33;
        rs1_addr = 1; rs2_addr = 2;
        #1;
        want = BYP ? 32'h33 : 32'h22;
        checks++;
        if (rs1_data !== 32'h11 || rs2_data !== want) begin
            errors++;
            $display("FAIL dual_read_same_cycle: rs1=%h rs2=%h, required 11 %h", rs1_data, rs2_data, want);
        end
        tick();
        wb_reg_enable = 1'b0;
        #1;
        checks++;
        if (rs2_data !== 32'h33) begin
            errors++;
            $display("FAIL dual_read_after_edge: rs2=%h, required 33", rs2_data);
        end
    endtask

    task automatic test_back_to_back();
        write_reg(5'd9, 32'h1111_0000);
        write_reg(5'd9, 32'h2222_0000);
        rs1_addr = 9; rs2_addr = 9; dbg_addr = 9;
        #1;
        checks++;
        if (rs1_data !== 32'h2222_0000 || rs2_data !== 32'h2222_0000 || dbg_data !== 32'h2222_0000) begin
            errors++;
            $display("FAIL back_to_back: rs1=%h rs2=%h dbg=%h, required 22220000", rs1_data, rs2_data, dbg_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2, ed;
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 29) == 0);
            wb_reg_enable = $urandom_range(0, 3) != 0;
            wb_rd_addr    = 5'($urandom_range(0, 31));
            wb_data       = $urandom;
            rs1_addr      = $urandom_range(0, 1) ? wb_rd_addr : 5'($urandom_range(0, 31));
            rs2_addr      = $urandom_range(0, 2) == 0 ? rs1_addr : 5'($urandom_range(0, 31));
            dbg_addr      = $urandom_range(0, 1) ? wb_rd_addr : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(rs1_addr);
            e2 = exp_rd(rs2_addr);
            ed = model[dbg_addr];
            checks++;
            if (rs1_data !== e1 || rs2_data !== e2 || dbg_data !== ed) begin
                errors++;
                $display("FAIL random n=%0d rs1[%0d]=%h/%h rs2[%0d]=%h/%h dbg[%0d]=%h/%h (actual/required)",
                         n, rs1_addr, rs1_data, e1, rs2_addr, rs2_data, e2, dbg_addr, dbg_data, ed);
            end
            tick();
        end
        reset = 1'b0; wb_reg_enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_basic_write();
        test_x0();
        test_bypass();
        test_reset_priority();
        test_dual_read();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
